// File: rtl/heavy_table_pkg.sv
// Shared widths, dump record size and FSM states for the heavy-part table dump controller.
package heavy_table_pkg;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 96;
   localparam int DEPTH  = 4096;
   localparam int REC_W  = ADDR_W + DATA_W;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      SWEEP,
      DRAIN,
      DONE
   } state_t;
endpackage

// File: rtl/heavy_part_table_dump_ctrl_if.sv
// Dump control, pipeline RAM access, table RAM and dump record signals of the dump controller.
interface heavy_part_table_dump_ctrl_if #(
   parameter int ADDR_W = heavy_table_pkg::ADDR_W,
   parameter int DATA_W = heavy_table_pkg::DATA_W
);
   logic                     dump_req;
   logic                     dump_clear;
   logic                     dump_busy;
   logic                     dump_done;
   logic                     pipe_hold;
   logic                     pipe_idle;
   logic                     pipe_rden;
   logic [ADDR_W-1:0]        pipe_rdaddr;
   logic                     pipe_wren;
   logic [ADDR_W-1:0]        pipe_wraddr;
   logic [DATA_W-1:0]        pipe_wrdata;
   logic [DATA_W-1:0]        pipe_rdvalue;
   logic                     ram_rden;
   logic [ADDR_W-1:0]        ram_rdaddr;
   logic                     ram_wren;
   logic [ADDR_W-1:0]        ram_wraddr;
   logic [DATA_W-1:0]        ram_wrdata;
   logic [DATA_W-1:0]        ram_q;
   logic                     dump_out_wr;
   logic [ADDR_W+DATA_W-1:0] dump_out;
   logic                     dump_out_alf;
   logic [7:0]               drop_cnt;

   modport master (
      input  dump_req, dump_clear, pipe_idle, pipe_rden, pipe_rdaddr, pipe_wren,
             pipe_wraddr, pipe_wrdata, ram_q, dump_out_alf,
      output dump_busy, dump_done, pipe_hold, pipe_rdvalue, ram_rden, ram_rdaddr,
             ram_wren, ram_wraddr, ram_wrdata, dump_out_wr, dump_out, drop_cnt
   );

   modport slave (
      output dump_req, dump_clear, pipe_idle, pipe_rden, pipe_rdaddr, pipe_wren,
             pipe_wraddr, pipe_wrdata, ram_q, dump_out_alf,
      input  dump_busy, dump_done, pipe_hold, pipe_rdvalue, ram_rden, ram_rdaddr,
             ram_wren, ram_wraddr, ram_wrdata, dump_out_wr, dump_out, drop_cnt
   );
endinterface

// File: rtl/heavy_table_sweep_addr.sv
// Sweep address counter plus tracking of the single read in flight (valid flag and its address).
// The counter parks on the terminal address; the terminal is compared explicitly, never by wrap.
module heavy_table_sweep_addr #(
   parameter int ADDR_W = heavy_table_pkg::ADDR_W,
   parameter int DEPTH  = heavy_table_pkg::DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              issue,
   output logic [ADDR_W-1:0] addr,
   output logic              last,
   output logic              q_vld,
   output logic [ADDR_W-1:0] q_addr
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   assign last = (addr == LAST_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr   <= '0;
         q_vld  <= 1'b0;
         q_addr <= '0;
      end else begin
         q_vld <= issue;
         if (issue) q_addr <= addr;
         if (start) addr <= '0;
         else if (issue && !last) addr <= addr + ADDR_W'(1);
      end
   end
endmodule

// File: rtl/heavy_part_table_dump_ctrl.sv
// Holds the lookup pipeline, sweeps every table entry out as {addr, entry} (optionally zeroing it),
// stalls reads on dump_out_alf; records appear two cycles after their read is issued.
module heavy_part_table_dump_ctrl #(
   parameter int ADDR_W = heavy_table_pkg::ADDR_W,
   parameter int DATA_W = heavy_table_pkg::DATA_W,
   parameter int DEPTH  = heavy_table_pkg::DEPTH
) (
   input logic                         clk,
   input logic                         reset,
   heavy_part_table_dump_ctrl_if.master bus
);
   import heavy_table_pkg::*;

   state_t                     state;
   logic                       clr_q;
   logic                       busy_r;
   logic                       hold_r;
   logic                       done_r;
   logic                       out_wr_r;
   logic [ADDR_W+DATA_W-1:0]   out_r;
   logic [7:0]                 drop_r;
   logic                       own;
   logic                       issue;
   logic                       start;
   logic [ADDR_W-1:0]          sw_addr;
   logic                       sw_last;
   logic                       q_vld;
   logic [ADDR_W-1:0]          q_addr;

   assign own   = (state == SWEEP) || (state == DRAIN) || (state == DONE);
   assign issue = (state == SWEEP) && !bus.dump_out_alf;
   assign start = (state == HOLD) && bus.pipe_idle;

   heavy_table_sweep_addr #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_sweep_addr (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .issue  (issue),
      .addr   (sw_addr),
      .last   (sw_last),
      .q_vld  (q_vld),
      .q_addr (q_addr)
   );

   // Clear write targets the returning address while the counter has already moved on,
   // so the engine never reads and writes one entry in the same cycle.
   always_comb begin
      bus.ram_rden   = 1'b0;
      bus.ram_rdaddr = bus.pipe_rdaddr;
      bus.ram_wren   = 1'b0;
      bus.ram_wraddr = bus.pipe_wraddr;
      bus.ram_wrdata = bus.pipe_wrdata;
      if (own) begin
         bus.ram_rden   = issue;
         bus.ram_rdaddr = sw_addr;
         bus.ram_wren   = clr_q && q_vld;
         bus.ram_wraddr = q_addr;
         bus.ram_wrdata = '0;
      end else if (!reset) begin
         bus.ram_rden = bus.pipe_rden;
         bus.ram_wren = bus.pipe_wren;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         clr_q    <= 1'b0;
         busy_r   <= 1'b0;
         hold_r   <= 1'b0;
         done_r   <= 1'b0;
         out_wr_r <= 1'b0;
         out_r    <= '0;
         drop_r   <= '0;
      end else begin
         done_r   <= 1'b0;
         out_wr_r <= q_vld;
         if (q_vld) out_r <= {q_addr, bus.ram_q};
         if (own && (bus.pipe_rden || bus.pipe_wren) && (drop_r != 8'hFF))
            drop_r <= drop_r + 8'd1;
         case (state)
            IDLE: if (bus.dump_req) begin
               state  <= HOLD;
               clr_q  <= bus.dump_clear;
               drop_r <= '0;
               busy_r <= 1'b1;
               hold_r <= 1'b1;
            end
            HOLD:  if (bus.pipe_idle) state <= SWEEP;
            SWEEP: if (issue && sw_last) state <= DRAIN;
            // Leave only once the last read has returned and its record has been written.
            DRAIN: if (!q_vld) begin
               state  <= DONE;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               hold_r <= 1'b0;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.dump_busy    = busy_r;
   assign bus.dump_done    = done_r;
   assign bus.pipe_hold    = hold_r;
   assign bus.dump_out_wr  = out_wr_r;
   assign bus.dump_out     = out_r;
   assign bus.drop_cnt     = drop_r;
   assign bus.pipe_rdvalue = bus.ram_q;
endmodule

// File: tb/tb_heavy_part_table_dump_ctrl.sv
// Bench for heavy_part_table_dump_ctrl: table RAM model, pass-through vectors, full-table dumps.
module tb_heavy_part_table_dump_ctrl;
   import heavy_table_pkg::*;

   localparam int AW = ADDR_W;
   localparam int DW = DATA_W;
   localparam int N  = DEPTH;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   heavy_part_table_dump_ctrl_if bif ();
   heavy_part_table_dump_ctrl dut (.clk(clk), .reset(reset), .bus(bif));

   logic [DW-1:0] mem [N];
   always @(posedge clk) begin
      if (bif.ram_wren) mem[bif.ram_wraddr] <= bif.ram_wrdata;
      if (bif.ram_rden) bif.ram_q <= mem[bif.ram_rdaddr];
   end

   int checks = 0;
   int failures = 0;
   logic [DW-1:0] shadow [N];
   logic [AW+DW-1:0] exp_q [$];
   int first_rd, first_wr, last_wr, done_cyc, nrec, nmis, nonzero;
   int hold_err, alf_err, wr_leak, exp_drop, quiet;
   logic [7:0] drop_seen;
   logic [DW-1:0] rec7;
   bit rst_hit;

   typedef struct {
      logic          rd;
      logic [AW-1:0] ra;
      logic          wr;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [121:0]  exp;
   } vec_t;
   vec_t vt [8];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      bif.dump_req     = 1'b0;
      bif.dump_clear   = 1'b0;
      bif.pipe_idle    = 1'b1;
      bif.pipe_rden    = 1'b0;
      bif.pipe_rdaddr  = '0;
      bif.pipe_wren    = 1'b0;
      bif.pipe_wraddr  = '0;
      bif.pipe_wrdata  = '0;
      bif.dump_out_alf = 1'b0;
   endtask

   task automatic preload(input bit with_a5);
      logic [DW-1:0] d;
      for (int a = 0; a < N; a++) begin
         d = DW'({$urandom, $urandom, $urandom});
         if (with_a5 && a == 7) d = DW'(96'hA5);
         shadow[a] = d;
         bif.pipe_wren = 1'b1;
         bif.pipe_wraddr = AW'(a);
         bif.pipe_wrdata = d;
         @(posedge clk); #1;
      end
      drive_idle();
   endtask

   task automatic run_dump(input bit clr, input int idle_lo, input int alf_s, input int alf_n,
                           input bit rnd_alf, input int drop_n, input bit drop_rd, input int rst_addr);
      logic [AW+DW-1:0] e;
      bit rd_i, wr_i, alf_i, probe, stop;
      exp_q.delete();
      for (int a = 0; a < N; a++) exp_q.push_back({AW'(a), shadow[a]});
      first_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
      nrec = 0; nmis = 0; nonzero = 0; hold_err = 0; alf_err = 0; wr_leak = 0; exp_drop = 0;
      rec7 = '0; rst_hit = 0; stop = 0; drop_seen = 8'h5A;
      for (int k = 0; k < 8000 && !stop; k++) begin
         probe = (idle_lo > 5) && (k == 5);
         alf_i = (k >= alf_s && k < alf_s + alf_n) || (rnd_alf && k >= 2 && $urandom_range(0, 7) == 0);
         rd_i = 1'b0;
         wr_i = 1'b0;
         if (k >= 10 && k < 10 + drop_n) begin
            if (drop_rd) begin
               rd_i = 1'($urandom_range(0, 1));
               wr_i = 1'($urandom_range(0, 1));
            end else wr_i = 1'b1;
         end
         if (rd_i || wr_i) exp_drop++;
         bif.dump_req     = (k == 0) || (k == 100);
         bif.dump_clear   = (k == 0) ? clr : !clr;
         bif.pipe_idle    = (k >= idle_lo);
         bif.dump_out_alf = alf_i;
         bif.pipe_rden    = rd_i || probe;
         bif.pipe_rdaddr  = probe ? AW'(123) : AW'($urandom);
         bif.pipe_wren    = wr_i;
         bif.pipe_wraddr  = AW'($urandom);
         bif.pipe_wrdata  = DW'({$urandom, $urandom, $urandom}) | DW'(1);
         @(negedge clk);
         if (probe) check("hold_passthru", 128'({bif.ram_rden, bif.ram_rdaddr}), 128'({1'b1, AW'(123)}));
         if (bif.ram_rden && !probe) begin
            if (first_rd < 0) first_rd = k;
            if (alf_i) alf_err++;
         end
         if (bif.ram_wren && (!clr || bif.ram_wrdata != '0)) wr_leak++;
         if (bif.dump_out_wr) begin
            if (first_wr < 0) first_wr = k;
            last_wr = k;
            nrec++;
            if (exp_q.size() == 0) nmis++;
            else begin
               e = exp_q.pop_front();
               if (bif.dump_out !== e) nmis++;
            end
            if (bif.dump_out[DW-1:0] != '0) nonzero++;
            if (bif.dump_out[AW+DW-1:DW] == AW'(7)) rec7 = bif.dump_out[DW-1:0];
         end
         if (bif.dump_done) begin
            done_cyc = k;
            stop = 1;
         end else if (k >= 1 && !(bif.pipe_hold && bif.dump_busy)) hold_err++;
         if (rst_addr >= 0 && k > 2 && bif.ram_rden && bif.ram_rdaddr == AW'(rst_addr)) begin
            rst_hit = 1;
            stop = 1;
         end
         if (!stop) begin
            @(posedge clk); #1;
         end
      end
      if (rst_hit) begin
         @(posedge clk); #1;
         drive_idle();
         reset = 1'b1;
         #1;
         check("rst_ctrl_outputs", 128'({bif.dump_busy, bif.dump_done, bif.pipe_hold, bif.dump_out_wr,
                                          bif.ram_rden, bif.ram_wren, bif.drop_cnt}), 128'(0));
         check("rst_dump_out", 128'(bif.dump_out), 128'(0));
         if (clr) for (int a = 0; a < rst_addr; a++) shadow[a] = '0;
      end else if (done_cyc >= 0) begin
         @(posedge clk); #1;
         drive_idle();
         @(negedge clk);
         check("done_single_cycle", 128'({bif.dump_done, bif.dump_busy, bif.pipe_hold}), 128'(0));
         drop_seen = bif.drop_cnt;
         @(posedge clk); #1;
         if (clr) for (int a = 0; a < N; a++) shadow[a] = '0;
      end else drive_idle();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy_done_hold", 128'({bif.dump_busy, bif.dump_done, bif.pipe_hold}), 128'(0));
      check("reset_out_wr", 128'(bif.dump_out_wr), 128'(0));
      check("reset_dump_out", 128'(bif.dump_out), 128'(0));
      check("reset_drop_cnt", 128'(bif.drop_cnt), 128'(0));
      check("reset_ram_en", 128'({bif.ram_rden, bif.ram_wren}), 128'(0));
      reset = 1'b0;
      @(negedge clk);
      check("idle_hold_busy", 128'({bif.pipe_hold, bif.dump_busy}), 128'(0));
      @(posedge clk); #1;

      // IDLE pass-through vectors: the RAM ports mirror the pipeline ports.
      vt[0].rd = 1'b0; vt[0].ra = AW'(0);    vt[0].wr = 1'b0; vt[0].wa = AW'(1);    vt[0].wd = '0;
      vt[1].rd = 1'b1; vt[1].ra = AW'(4095); vt[1].wr = 1'b0; vt[1].wa = AW'(0);    vt[1].wd = '1;
      vt[2].rd = 1'b0; vt[2].ra = AW'(17);   vt[2].wr = 1'b1; vt[2].wa = AW'(4095); vt[2].wd = DW'(96'hDEAD_BEEF);
      vt[3].rd = 1'b1; vt[3].ra = AW'(5);    vt[3].wr = 1'b1; vt[3].wa = AW'(6);    vt[3].wd = '1;
      for (int i = 4; i < 8; i++) begin
         vt[i].rd = 1'($urandom_range(0, 1));
         vt[i].ra = AW'($urandom);
         vt[i].wr = 1'($urandom_range(0, 1));
         vt[i].wa = vt[i].ra + AW'(1);
         vt[i].wd = DW'({$urandom, $urandom, $urandom});
      end
      for (int i = 0; i < 8; i++) vt[i].exp = {vt[i].rd, vt[i].ra, vt[i].wr, vt[i].wa, vt[i].wd};
      for (int i = 0; i < 8; i++) begin
         bif.pipe_rden = vt[i].rd;   bif.pipe_rdaddr = vt[i].ra;
         bif.pipe_wren = vt[i].wr;   bif.pipe_wraddr = vt[i].wa;   bif.pipe_wrdata = vt[i].wd;
         @(negedge clk);
         check($sformatf("idle_vec%0d", i),
               128'({bif.ram_rden, bif.ram_rdaddr, bif.ram_wren, bif.ram_wraddr, bif.ram_wrdata}),
               128'(vt[i].exp));
         @(posedge clk); #1;
      end
      drive_idle();

      preload(1'b1);
      for (int i = 0; i < 3; i++) begin
         int ad;
         ad = (i == 0) ? 7 : (i == 1) ? 1234 : 4095;
         bif.pipe_rden = 1'b1;
         bif.pipe_rdaddr = AW'(ad);
         @(posedge clk); #1;
         bif.pipe_rden = 1'b0;
         @(negedge clk);
         check($sformatf("rdvalue_%0d", ad), 128'(bif.pipe_rdvalue), 128'(shadow[ad]));
         @(posedge clk); #1;
      end

      // Full dump without clear: fixed cycle timing from the request.
      run_dump(1'b0, 0, 100000, 0, 1'b0, 0, 1'b0, -1);
      check("A_first_read", 128'(first_rd), 128'(2));
      check("A_first_record", 128'(first_wr), 128'(4));
      check("A_last_record", 128'(last_wr), 128'(4099));
      check("A_done_cycle", 128'(done_cyc), 128'(4100));
      check("A_records", 128'({nrec, nmis}), 128'({32'(N), 32'(0)}));
      check("A_hold_busy", 128'(hold_err), 128'(0));
      check("A_no_write", 128'(wr_leak), 128'(0));
      check("A_drop_cnt", 128'(drop_seen), 128'(0));

      // Pipeline busy for 10 cycles, then a 5-cycle alf burst mid-sweep.
      run_dump(1'b0, 11, 1000, 5, 1'b0, 0, 1'b0, -1);
      check("D_first_read", 128'(first_rd), 128'(12));
      check("D_hold_busy", 128'(hold_err), 128'(0));
      check("D_alf_reads", 128'(alf_err), 128'(0));
      check("D_records", 128'({nrec, nmis}), 128'({32'(N), 32'(0)}));
      check("D_done_cycle", 128'(done_cyc), 128'(4115));

      // Clearing dump with 300 dropped pipeline writes.
      run_dump(1'b1, 0, 100000, 0, 1'b0, 300, 1'b0, -1);
      check("B_entry7", 128'(rec7), 128'(96'hA5));
      check("B_records", 128'({nrec, nmis}), 128'({32'(N), 32'(0)}));
      check("B_no_pipe_write", 128'(wr_leak), 128'(0));
      check("B_drop_sat", 128'(drop_seen), 128'(exp_drop > 255 ? 255 : exp_drop));
      check("B_done_cycle", 128'(done_cyc), 128'(4100));

      // Table now all zero; random alf and random read/write drops.
      run_dump(1'b0, 0, 100000, 0, 1'b1, 200, 1'b1, -1);
      check("C_done", 128'(done_cyc > 0), 128'(1));
      check("C_zero_entries", 128'({nrec, nonzero}), 128'({32'(N), 32'(0)}));
      check("C_records", 128'(nmis), 128'(0));
      check("C_alf_reads", 128'(alf_err), 128'(0));
      check("C_drop_cnt", 128'(drop_seen), 128'(exp_drop > 255 ? 255 : exp_drop));

      // Reset in the middle of a clearing sweep, then a fresh dump.
      preload(1'b0);
      run_dump(1'b1, 0, 100000, 0, 1'b0, 0, 1'b0, 1000);
      check("R_reset_hit", 128'({rst_hit, done_cyc}), 128'({1'b1, -32'sd1}));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bif.dump_done || bif.dump_busy || bif.pipe_hold) quiet++;
         @(posedge clk); #1;
      end
      check("R_no_done", 128'(quiet), 128'(0));
      run_dump(1'b0, 0, 100000, 0, 1'b0, 0, 1'b0, -1);
      check("R_redump_done", 128'(done_cyc), 128'(4100));
      check("R_partial_clear", 128'({nrec, nmis}), 128'({32'(N), 32'(0)}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/heavy_part_table_dump_ctrl.md
HEAVY_PART_TABLE_DUMP_CTRL -- requirements
Module: heavy_part_table_dump_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_W, 12, table address width.
- DATA_W, 96, entry width.
- DEPTH, 4096, entries swept per dump.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 dump_req  in  1  one-cycle dump request.
REQ-005 dump_clear  in  1  sampled with dump_req; 1 = zero each entry after reading it.
REQ-006 dump_busy  out  1  high from accepted request until done.
REQ-007 dump_done  out  1  one-cycle completion pulse.
REQ-008 pipe_hold  out  1  to upstream ip_addr_in_alf; stops new keys entering.
REQ-009 pipe_idle  in  1  high when the lookup/compare pipeline has nothing in flight.
REQ-010 pipe_rden / pipe_rdaddr  in  1 / ADDR_W  pipeline read port.
REQ-011 pipe_wren / pipe_wraddr / pipe_wrdata  in  1 / ADDR_W / DATA_W  pipeline write port.
REQ-012 pipe_rdvalue  out  DATA_W  ram_q passed through to the pipeline.
REQ-013 ram_rden / ram_rdaddr / ram_wren / ram_wraddr / ram_wrdata  out  table RAM ports.
REQ-014 ram_q  in  DATA_W  RAM read data, valid one cycle after ram_rden.
REQ-015 dump_out_wr / dump_out  out  1 / ADDR_W+DATA_W  dumped record {addr, entry}.
REQ-016 dump_out_alf  in  1  downstream almost-full.
REQ-017 drop_cnt  out  8  saturating count of pipeline accesses dropped during the sweep.

Function
REQ-018 States SHALL be IDLE, HOLD, SWEEP, DRAIN, DONE.
REQ-019 IDLE: dump_req=1 -> HOLD; latch dump_clear; clear drop_cnt.
REQ-020 HOLD: pipe_hold=1; pipe_idle=1 -> SWEEP, with the address counter reset to 0.
REQ-021 SWEEP: each cycle with dump_out_alf=0, issue ram_rden at the counter address, then increment the counter.
REQ-022 SWEEP: when dump_out_alf=1, issue no read; reads already in flight still complete.
REQ-023 SWEEP: after the read at address DEPTH-1 is issued, go to DRAIN.
REQ-024 DRAIN: wait for the last ram_q and its clear write, then go to DONE.
REQ-025 DONE: dump_done=1 for one cycle; pipe_hold and dump_busy drop; go to IDLE.
REQ-026 In IDLE and HOLD, RAM ports SHALL be driven combinationally from the pipe_* ports.
REQ-027 In SWEEP, DRAIN and DONE, RAM ports SHALL be driven by the engine.
REQ-028 A pipe_rden or pipe_wren while the engine owns the RAM SHALL be dropped.
REQ-029 Each dropped access SHALL increment drop_cnt, saturating at 255; simultaneous read and write drops count 1.
REQ-030 dump_out SHALL be registered: {issued address, ram_q}, with dump_out_wr one cycle after ram_q is valid.
REQ-031 When clear is latched: ram_wren=1, ram_wraddr = returned address, ram_wrdata = 0, in the ram_q-valid cycle.
REQ-032 The engine SHALL never read and write the same address in the same cycle.
REQ-033 dump_req outside IDLE SHALL be ignored.
REQ-034 The counter SHALL be ADDR_W wide; the DEPTH-1 terminal is detected explicitly, without relying on wrap.
REQ-035 In IDLE, pipe_hold=0 and dump_busy=0.

Reset
REQ-036 Reset SHALL force state IDLE, counter 0, latched clear 0, drop_cnt 0.
REQ-037 Reset SHALL force dump_busy, dump_done, pipe_hold, dump_out_wr, ram_rden and ram_wren to 0, and dump_out to 0.
REQ-038 Reset mid-sweep SHALL abandon the dump with no dump_done; the table holds a partially cleared state.

Structure
REQ-039 heavy_table_pkg SHALL hold ADDR_W, DATA_W, DEPTH, the state enum and the dump record width.
REQ-040 The address counter and in-flight tracking SHALL be one sub-module, heavy_table_sweep_addr; the FSM and RAM mux stay in the top.

Verification
REQ-041 Full dump: dump_req at cycle 0, dump_clear=0, pipe_idle=1, alf=0 -> SWEEP at cycle 2; dump_out_wr cycles 4..4099 with addresses 0..4095; dump_done at cycle 4100.
REQ-042 Clear dump: preload entry 7 = 96'hA5, dump with clear -> record {7, A5}; a second dump returns all zero entries.
REQ-043 Drain wait: pipe_idle low for 10 cycles after the request -> pipe_hold high throughout; no ram_rden from the engine until pipe_idle=1.
REQ-044 Backpressure: alf high for 5 cycles mid-sweep -> no address skipped or duplicated; 4096 records in order.
REQ-045 Drops: 300 pipe_wren pulses during the sweep -> no write reaches the RAM; drop_cnt=255.
REQ-046 Reset at address 1000 -> all outputs 0 next cycle; no dump_done; a new dump_req is accepted afterwards.
